ts_capture: RTL and testbench

TS_CAPTURE -- requirements
Module: ts_capture

---
 rtl/ts_pkg.sv | 35 +++
 rtl/ts_fifo.sv | 70 +++++++
 rtl/ts_capture.sv | 134 +++++++++++++
 tb/tb_ts_capture.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared definitions for the timestamp capture block.
// Record layout and source encoding used by the capture path and its FIFO.
package ts_pkg;

    localparam int SEQ_W = 16;
    localparam int TS_W  = 64;
    localparam int REC_W = 1 + SEQ_W + TS_W;

    localparam logic SRC_TX = 1'b0;
    localparam logic SRC_RX = 1'b1;

    typedef struct packed {
        logic             src;
        logic [SEQ_W-1:0] seq;
        logic [TS_W-1:0]  ts;
    } ts_rec_t;

    // Saturating add of a small increment onto a counter of width w.
    function automatic logic [63:0] sat_add(
        input logic [63:0] cnt,
        input logic [1:0]  inc,
        input int          w
    );
        logic [64:0] sum;
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum = {1'b0, cnt} + {63'd0, inc};
        if (sum > {1'b0, top}) begin
            sat_add = top;
        end else begin
            sat_add = sum[63:0];
        end
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through record FIFO with a registered read stage.
// The head entry stays counted in level until the consumer pops it.
module ts_fifo
    import ts_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  ts_rec_t                wr_data,
    output logic                   wr_ready,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output ts_rec_t                rd_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    ts_rec_t        mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  rd_ptr_n;
    logic           full;
    logic           pop;
    logic           push;
    logic           fill;

    // Handshake, occupancy and the head pointer for the next cycle.
    always_comb begin
        pop      = rd_valid & rd_ready;
        full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_ready = ~full | pop;
        push     = wr_en & wr_ready;
        rd_ptr_n = rd_ptr + PW'(pop);
        fill     = (rd_ptr_n != wr_ptr);
        level    = wr_ptr - rd_ptr;
    end

    // Storage array; a slot is only written once the reader has left it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers and output register; head is refreshed from pre-write state
    // so a new entry shows up the cycle after it is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr   <= rd_ptr_n;
            rd_valid <= fill;
            if (fill) begin
                rd_data <= mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ts_capture.sv
// PTP start-of-frame timestamp capture: tx/rx pending slots feeding one FIFO.
// Lost events are counted in a saturating drop counter with a sticky flag.
module ts_capture
    import ts_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   tx_sof,
    input  logic                   rx_sof,
    input  logic [TS_W-1:0]        time_ptp_ns,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_src,
    output logic [SEQ_W-1:0]       m_seq,
    output logic [TS_W-1:0]        m_ts,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   overflow,
    input  logic                   clr,
    output logic [$clog2(DEPTH):0] level
);

    logic             tx_pend;
    logic             rx_pend;
    logic [TS_W-1:0]  tx_ts;
    logic [TS_W-1:0]  rx_ts;
    logic [SEQ_W-1:0] seq;

    logic             tx_evt;
    logic             rx_evt;
    logic             grant_tx;
    logic             grant_rx;
    logic             wr_req;
    logic             wr_ready;
    logic             wr_ok;
    logic             fifo_drop;
    logic             tx_drop;
    logic             rx_drop;
    logic [1:0]       n_drop;
    logic [DROP_W:0]  drop_sum;
    logic [DROP_W-1:0] drop_next;
    ts_rec_t          wr_rec;
    ts_rec_t          rd_rec;

    // Arbitration, drop detection and the record offered to the FIFO.
    always_comb begin
        tx_evt    = en & tx_sof;
        rx_evt    = en & rx_sof;
        grant_tx  = tx_pend;
        grant_rx  = rx_pend & ~tx_pend;
        wr_req    = grant_tx | grant_rx;
        wr_ok     = wr_req & wr_ready;
        fifo_drop = wr_req & ~wr_ready;
        tx_drop   = tx_evt & tx_pend & ~grant_tx;
        rx_drop   = rx_evt & rx_pend & ~grant_rx;
        n_drop    = {1'b0, tx_drop} + {1'b0, rx_drop} + {1'b0, fifo_drop};
        drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);
        drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        wr_rec.src = grant_tx ? SRC_TX : SRC_RX;
        wr_rec.seq = seq;
        wr_rec.ts  = grant_tx ? tx_ts : rx_ts;
    end

    // Tx pending slot: reload when empty or being served, else hold old stamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pend <= 1'b0;
            tx_ts   <= '0;
        end else if (tx_evt && (!tx_pend || grant_tx)) begin
            tx_pend <= 1'b1;
            tx_ts   <= time_ptp_ns;
        end else if (grant_tx) begin
            tx_pend <= 1'b0;
        end
    end

    // Rx pending slot: same policy, but it only drains when tx is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_pend <= 1'b0;
            rx_ts   <= '0;
        end else if (rx_evt && (!rx_pend || grant_rx)) begin
            rx_pend <= 1'b1;
            rx_ts   <= time_ptp_ns;
        end else if (grant_rx) begin
            rx_pend <= 1'b0;
        end
    end

    // Sequence number advances only for records that reach the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq <= '0;
        end else if (wr_ok) begin
            seq <= seq + SEQ_W'(1);
        end
    end

    // Loss accounting; a clear in the same cycle as a loss takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (n_drop != 2'd0) begin
            drop_cnt <= drop_next;
            overflow <= 1'b1;
        end
    end

    ts_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_req),
        .wr_data  (wr_rec),
        .wr_ready (wr_ready),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (rd_rec),
        .level    (level)
    );

    assign m_src = rd_rec.src;
    assign m_seq = rd_rec.seq;
    assign m_ts  = rd_rec.ts;

endmodule

// File: tb/tb_ts_capture.sv
// Scoreboard bench for ts_capture: expected records are queued as events
// are driven and matched against every accepted output record.
module tb_ts_capture;
    import ts_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              tx_sof = 1'b0;
    logic              rx_sof = 1'b0;
    logic [63:0]       time_ptp_ns = 64'd0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_src;
    logic [15:0]       m_seq;
    logic [63:0]       m_ts;
    logic [DROP_W-1:0] drop_cnt;
    logic              overflow;
    logic              clr = 1'b0;
    logic [LW-1:0]     level;

    int          total = 0;
    int          bad = 0;
    ts_rec_t     exp_q[$];
    logic [15:0] nseq = 16'd0;
    logic [15:0] last_seq = 16'hFFFF;
    logic [63:0] t0;

    ts_capture #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .en(en), .tx_sof(tx_sof), .rx_sof(rx_sof),
        .time_ptp_ns(time_ptp_ns), .m_valid(m_valid), .m_ready(m_ready),
        .m_src(m_src), .m_seq(m_seq), .m_ts(m_ts), .drop_cnt(drop_cnt),
        .overflow(overflow), .clr(clr), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [80:0] got,
                         input logic [80:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        time_ptp_ns = time_ptp_ns + 64'd3;
    endtask

    task automatic expect_rec(input logic s, input logic [63:0] ts);
        ts_rec_t r;
        r.src = s;
        r.seq = nseq;
        r.ts  = ts;
        exp_q.push_back(r);
        nseq = nseq + 16'd1;
    endtask

    task automatic pulse(input logic t, input logic r);
        tx_sof = t;
        rx_sof = r;
        step();
        tx_sof = 1'b0;
        rx_sof = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        tx_sof = 1'b0;
        rx_sof = 1'b0;
        clr = 1'b0;
        exp_q.delete();
        nseq = 16'd0;
        step();
        step();
        rst = 1'b0;
        en = 1'b1;
        step();
    endtask

    task automatic drain(input int budget);
        m_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        step();
        step();
        check("drain", 81'(exp_q.size()), 81'd0);
        check("lvl_empty", 81'(level), 81'd0);
    endtask

    // Scoreboard: compare each accepted record with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_rec", 81'(m_valid), 81'd0);
            end else begin
                check("rec", {m_src, m_seq, m_ts}, exp_q.pop_front());
                last_seq = m_seq;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("rst_valid", 81'(m_valid), 81'd0);
        check("rst_level", 81'(level), 81'd0);
        check("rst_drop", 81'(drop_cnt), 81'd0);
        check("rst_ovf", 81'(overflow), 81'd0);
        check("rst_rec", {m_src, m_seq, m_ts}, 81'd0);
        rst = 1'b0;
        en = 1'b1;
        step();

        // single event latency
        m_ready = 1'b1;
        time_ptp_ns = 64'h1000;
        expect_rec(SRC_TX, 64'h1000);
        pulse(1'b1, 1'b0);
        check("lat0", 81'(m_valid), 81'd0);
        step();
        check("lat1", 81'(m_valid), 81'd0);
        step();
        check("lat2", 81'(m_valid), 81'd1);
        step();
        check("one_cyc", 81'(m_valid), 81'd0);
        check("q_single", 81'(exp_q.size()), 81'd0);

        // simultaneous tx and rx
        do_reset();
        m_ready = 1'b1;
        time_ptp_ns = 64'h2000;
        expect_rec(SRC_TX, 64'h2000);
        expect_rec(SRC_RX, 64'h2000);
        pulse(1'b1, 1'b1);
        step();
        step();
        check("sim_v0", {79'd0, m_valid, m_src}, {79'd0, 1'b1, SRC_TX});
        step();
        check("sim_v1", {79'd0, m_valid, m_src}, {79'd0, 1'b1, SRC_RX});
        step();
        check("sim_drop", 81'(drop_cnt), 81'd0);
        check("q_sim", 81'(exp_q.size()), 81'd0);

        // full FIFO with stalled consumer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < DEPTH) expect_rec(SRC_RX, time_ptp_ns);
            pulse(1'b0, 1'b1);
            step();
            step();
        end
        check("full_lvl", 81'(level), 81'd8);
        check("full_drop", 81'(drop_cnt), 81'd2);
        check("full_ovf", 81'(overflow), 81'd1);
        check("hold0", {m_src, m_seq, m_ts}, exp_q[0]);
        step();
        step();
        step();
        check("hold1", {m_src, m_seq, m_ts}, exp_q[0]);
        drain(60);

        // fifo drop and rx collision in the same cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            expect_rec(SRC_RX, time_ptp_ns);
            pulse(1'b0, 1'b1);
            step();
        end
        check("fill_lvl", 81'(level), 81'd8);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        check("dbl_drop", 81'(drop_cnt), 81'd2);
        step();
        check("drop3", 81'(drop_cnt), 81'd3);
        check("drop3_ovf", 81'(overflow), 81'd1);
        drain(60);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_drop", 81'(drop_cnt), 81'd0);
        check("clr_ovf", 81'(overflow), 81'd0);

        // pending collision keeps first rx stamp
        do_reset();
        m_ready = 1'b1;
        t0 = time_ptp_ns;
        expect_rec(SRC_TX, t0);
        expect_rec(SRC_TX, t0 + 64'd3);
        expect_rec(SRC_TX, t0 + 64'd6);
        expect_rec(SRC_RX, t0 + 64'd3);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        drain(30);
        check("col_drop", 81'(drop_cnt), 81'd1);
        check("col_ovf", 81'(overflow), 81'd1);

        // clear coinciding with a drop
        t0 = time_ptp_ns;
        expect_rec(SRC_TX, t0);
        expect_rec(SRC_TX, t0 + 64'd3);
        expect_rec(SRC_TX, t0 + 64'd6);
        expect_rec(SRC_RX, t0 + 64'd3);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        clr = 1'b1;
        pulse(1'b1, 1'b1);
        clr = 1'b0;
        check("clrw_drop", 81'(drop_cnt), 81'd0);
        check("clrw_ovf", 81'(overflow), 81'd0);
        drain(30);

        // reset mid-run
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0, 1'b1);
            step();
        end
        check("mid_lvl", 81'(level), 81'd5);
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid", 81'(m_valid), 81'd0);
        check("mid_level", 81'(level), 81'd0);
        exp_q.delete();
        nseq = 16'd0;
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("post_rst", 81'(m_valid), 81'd0);
        expect_rec(SRC_RX, time_ptp_ns);
        pulse(1'b0, 1'b1);
        drain(20);
        check("post_seq", 81'(last_seq), 81'd0);

        // sequence wrap
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            expect_rec(SRC_TX, time_ptp_ns);
            tx_sof = 1'b1;
            step();
        end
        tx_sof = 1'b0;
        drain(100);
        check("wrap_seq", 81'(last_seq), 81'd0);
        check("wrap_drop", 81'(drop_cnt), 81'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
